riscv_fetch_queue: RTL and testbench
====================================

# riscv_fetch_queue

Parametrised instruction-fetch front end for the pipelined core. It replaces the single-entry IF stage and IF/ID register with a DEPTH-entry prefetch queue. It issues in-order requests to an instruction memory with valid/ready handshakes and variable response latency. It delivers instructions to decode under a valid/ready stall handshake, and on a branch/jump redirect it discards all wrong-path entries and any still-outstanding responses.

## Interface
Parameters:
- XLEN, 32: data/address width.
- DEPTH, 4: queue entries, power of two, ≥2; also the maximum number of outstanding requests.
- RESET_PC, 0: first fetch address after reset.

Ports:
- i_clk  in  1  single clock, all state on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- o_imem_req_valid  out  1  fetch request valid.
- i_imem_req_ready  in  1  memory accepts request.
- o_imem_req_addr  out  XLEN  fetch address, word aligned.
- i_imem_rsp_valid  in  1  response valid; responses return in request order.
- i_imem_rsp_instr  in  XLEN  response instruction.
- i_redirect_valid  in  1  EX-stage redirect (taken branch/jump).
- i_redirect_pc  in  XLEN  redirect target.
- o_id_valid  out  1  head entry available to decode.
- i_id_ready  in  1  decode accepts head (0 = id stall).
- o_id_instr, o_id_pc, o_id_pc_plus_4  out  XLEN each  head instruction, its PC, PC+4.
- o_count  out  $clog2(DEPTH)+1  filled, unconsumed entries.

## Operation
- State: fetch_pc; three pointers alloc/fill/rd, each $clog2(DEPTH)+1 bits with wrap bit; drop_cnt, $clog2(DEPTH)+1 bits; entry storage {pc, instr}.
- Request: o_imem_req_valid = !i_rst && !i_redirect_valid && (alloc-rd) + drop_cnt < DEPTH. o_imem_req_addr = fetch_pc.
- On request fire: write pc into entry[alloc], alloc++, fetch_pc += 4 (mod 2^XLEN, wraps silently).
- Response fire while drop_cnt>0: discard the instruction, drop_cnt--.
- Response fire while drop_cnt==0: write instr into entry[fill], fill++.
- A response arriving when fill==alloc and drop_cnt==0 is a protocol error. It is ignored, and an assertion fires.
- Dequeue: o_id_valid = (fill != rd) && !i_redirect_valid. On o_id_valid && i_id_ready, rd++.
- o_id_* are 0 whenever o_id_valid=0.
- o_count = fill-rd.
- Redirect has priority over request, fill and dequeue in the same cycle:
  - alloc, fill and rd are all set equal to the current fill value, emptying the queue.
  - fetch_pc <= i_redirect_pc.
  - drop_cnt <= drop_cnt + (alloc-fill) - (rsp fire), so every pre-redirect outstanding response is dropped, including one arriving in the redirect cycle.
- Back-to-back redirects accumulate drop_cnt; the credit rule keeps drop_cnt ≤ DEPTH.
- A request may be withdrawn only in a redirect cycle. Otherwise valid and addr hold until ready.
- Full (alloc-rd == DEPTH, or credit exhausted): req_valid=0. Empty: o_id_valid=0. Simultaneous fill and dequeue are both allowed, and the count is unchanged.

## Timing
- Reset (i_rst=1 on an edge):
  - pointers 0, drop_cnt 0, fetch_pc=RESET_PC.
  - During reset: o_imem_req_valid=0, o_id_valid=0, o_count=0, o_id_*=0, o_imem_req_addr=RESET_PC.
  - Reset mid-operation discards everything. Responses to pre-reset requests must not arrive; the memory is reset alongside.
- First request is in the first cycle after reset deasserts.
- Response written at edge N; o_id_valid is high from cycle N+1 (1-cycle fill-to-decode latency).
- Full throughput of 1 instr/cycle requires DEPTH ≥ memory response latency + 1.
- After a redirect at edge R, the request for i_redirect_pc is issued in cycle R+1 if credit allows.
- No combinational path from i_imem_req_ready or i_id_ready to any output. The only combinational input-to-output path is i_redirect_valid → o_imem_req_valid / o_id_valid.

## Structure
- Shared constants go in the common riscv_configs include: XLEN, the reset vector used as RESET_PC, and the default FETCH_QUEUE_DEPTH.
- Sub-module riscv_fetch_entry_ram: DEPTH × (2·XLEN) storage with one write port for pc at alloc, one write port for instr at fill, and an async read at rd. No reset on storage.
- The top keeps pointers, credit, drop logic and assertions.

## Test plan
- Reset, then a 1-cycle-latency memory that is always ready, with i_id_ready=1: requests 0x0,0x4,0x8…; o_id_valid from the cycle after the first response, 1 instr/cycle, o_id_pc_plus_4 = pc+4.
- i_id_ready=0 for 10 cycles, DEPTH=4: exactly 4 requests are issued, o_count=4 and req_valid=0. Release ready: instructions drain in order with no loss or duplicates.
- 3-cycle latency with 3 outstanding, then a redirect to 0x100: those 3 responses are dropped (drop_cnt 3→0). The next delivered o_id_pc is 0x100, with no old instructions after the redirect.
- Redirect in the same cycle as a response and an id dequeue: o_id_valid=0 that cycle, the response is dropped, rd does not advance separately, and the queue is empty next cycle.
- i_imem_req_ready random at 50% with DEPTH=8: the addr/valid hold-stable rule is never violated, and the output stream is a contiguous PC sequence.
- Assert i_rst while the queue is full: the next cycle o_count=0 and o_id_valid=0, and the first request after deassertion is RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_queue_pkg.sv
// Shared core configuration for the fetch front end: data width, reset vector
// and the default prefetch queue depth.
package riscv_fetch_queue_pkg;

    localparam int unsigned CFG_XLEN              = 32;
    localparam logic [31:0] CFG_RESET_VECTOR      = 32'h0000_0000;
    localparam int unsigned CFG_FETCH_QUEUE_DEPTH = 4;

    // Pointer width carries one extra wrap bit so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/riscv_fetch_entry_ram.sv
// Prefetch queue storage: PC written at request time and instruction written at
// response time, each through its own port; asynchronous read of the head entry.
module riscv_fetch_entry_ram #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_pc_we,
    input  logic [$clog2(DEPTH)-1:0] i_pc_waddr,
    input  logic [XLEN-1:0]          i_pc_wdata,
    input  logic                     i_instr_we,
    input  logic [$clog2(DEPTH)-1:0] i_instr_waddr,
    input  logic [XLEN-1:0]          i_instr_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [XLEN-1:0]          o_rd_pc,
    output logic [XLEN-1:0]          o_rd_instr
);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_pc_we) begin
            pc_mem[i_pc_waddr] <= i_pc_wdata;
        end
        if (i_instr_we) begin
            instr_mem[i_instr_waddr] <= i_instr_wdata;
        end
    end

    assign o_rd_pc    = pc_mem[i_raddr];
    assign o_rd_instr = instr_mem[i_raddr];

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction fetch front end: DEPTH-entry prefetch queue with in-order memory
// requests, decode stall handshake and redirect flush of wrong-path fetches.
module riscv_fetch_queue
    import riscv_fetch_queue_pkg::*;
#(
    parameter int unsigned     XLEN     = CFG_XLEN,
    parameter int unsigned     DEPTH    = CFG_FETCH_QUEUE_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CFG_RESET_VECTOR)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic                   o_imem_req_valid,
    input  logic                   i_imem_req_ready,
    output logic [XLEN-1:0]        o_imem_req_addr,
    input  logic                   i_imem_rsp_valid,
    input  logic [XLEN-1:0]        i_imem_rsp_instr,
    input  logic                   i_redirect_valid,
    input  logic [XLEN-1:0]        i_redirect_pc,
    output logic                   o_id_valid,
    input  logic                   i_id_ready,
    output logic [XLEN-1:0]        o_id_instr,
    output logic [XLEN-1:0]        o_id_pc,
    output logic [XLEN-1:0]        o_id_pc_plus_4,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);
    typedef logic [PW-1:0] ptr_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    ptr_t            alloc_q, alloc_d;
    ptr_t            fill_q, fill_d;
    ptr_t            rd_q, rd_d;
    ptr_t            drop_q, drop_d;

    ptr_t            in_flight, occupied, filled;
    logic [PW:0]     credit_used;
    logic            req_valid, req_fire;
    logic            rsp_err, rsp_fire, rsp_keep;
    logic            id_valid, deq_fire;
    logic [XLEN-1:0] rd_pc, rd_instr;

    assign in_flight   = alloc_q - fill_q;
    assign occupied    = alloc_q - rd_q;
    assign filled      = fill_q - rd_q;
    // Responses still to be discarded hold queue credit until they return.
    assign credit_used = {1'b0, occupied} + {1'b0, drop_q};

    assign req_valid = !i_rst && !i_redirect_valid && (credit_used < (PW+1)'(DEPTH));
    assign req_fire  = req_valid && i_imem_req_ready;
    assign rsp_err   = i_imem_rsp_valid && (drop_q == '0) && (in_flight == '0);
    assign rsp_fire  = i_imem_rsp_valid && !rsp_err;
    assign rsp_keep  = rsp_fire && (drop_q == '0);
    assign id_valid  = !i_rst && !i_redirect_valid && (filled != '0);
    assign deq_fire  = id_valid && i_id_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        rd_d       = rd_q;
        drop_d     = drop_q;
        if (i_redirect_valid) begin
            // Everything requested but not yet returned becomes wrong-path, including
            // a response landing this very cycle.
            fetch_pc_d = i_redirect_pc;
            alloc_d    = fill_q;
            rd_d       = fill_q;
            drop_d     = drop_q + in_flight - ptr_t'(rsp_fire);
        end else begin
            if (req_fire) begin
                alloc_d    = alloc_q + ptr_t'(1);
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_keep) begin
                fill_d = fill_q + ptr_t'(1);
            end else if (rsp_fire) begin
                drop_d = drop_q - ptr_t'(1);
            end
            if (deq_fire) begin
                rd_d = rd_q + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_PC;
            alloc_q    <= '0;
            fill_q     <= '0;
            rd_q       <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            rd_q       <= rd_d;
            drop_q     <= drop_d;
        end
    end

    riscv_fetch_entry_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_entry_ram (
        .i_clk         (i_clk),
        .i_pc_we       (req_fire),
        .i_pc_waddr    (alloc_q[AW-1:0]),
        .i_pc_wdata    (fetch_pc_q),
        .i_instr_we    (rsp_keep && !i_redirect_valid),
        .i_instr_waddr (fill_q[AW-1:0]),
        .i_instr_wdata (i_imem_rsp_instr),
        .i_raddr       (rd_q[AW-1:0]),
        .o_rd_pc       (rd_pc),
        .o_rd_instr    (rd_instr)
    );

    assign o_imem_req_valid = req_valid;
    assign o_imem_req_addr  = i_rst ? RESET_PC : fetch_pc_q;
    assign o_id_valid       = id_valid;
    assign o_id_instr       = id_valid ? rd_instr : '0;
    assign o_id_pc          = id_valid ? rd_pc : '0;
    assign o_id_pc_plus_4   = id_valid ? rd_pc + XLEN'(4) : '0;
    assign o_count          = i_rst ? '0 : filled;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!rsp_err);
        end
    end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Scoreboard bench for riscv_fetch_queue: a latency-programmable memory model,
// directed redirect/stall/reset sequences and an output monitor.
module tb_riscv_fetch_queue;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic                   clk;
    logic                   rst;
    logic                   req_valid;
    logic                   req_ready;
    logic [XLEN-1:0]        req_addr;
    logic                   rsp_valid;
    logic [XLEN-1:0]        rsp_instr;
    logic                   redirect_valid;
    logic [XLEN-1:0]        redirect_pc;
    logic                   id_valid;
    logic                   id_ready;
    logic [XLEN-1:0]        id_instr;
    logic [XLEN-1:0]        id_pc;
    logic [XLEN-1:0]        id_pc4;
    logic [$clog2(DEPTH):0] count;

    riscv_fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_req_addr  (req_addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_instr (rsp_instr),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_id_valid       (id_valid),
        .i_id_ready       (id_ready),
        .o_id_instr       (id_instr),
        .o_id_pc          (id_pc),
        .o_id_pc_plus_4   (id_pc4),
        .o_count          (count)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] sb[$];
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          lat       = 1;
    int          pops      = 0;
    int          req_fires = 0;
    bit          rand_mode = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic sb_load(input logic [31:0] start);
        sb.delete();
        for (int i = 0; i < 128; i++) sb.push_back(start + 32'(4 * i));
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: answers in request order, each response no earlier than lat cycles.
    initial begin
        rsp_valid = 1'b0;
        rsp_instr = '0;
        req_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rst) begin
                pend.delete();
                rsp_valid = 1'b0;
                rsp_instr = '0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                rsp_valid = 1'b1;
                rsp_instr = instr_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                rsp_valid = 1'b0;
                rsp_instr = '0;
            end
        end
    end

    // Monitor: request capture, hold-stable rule, scoreboard compare on dequeue.
    initial begin
        logic        prev_hold;
        logic [31:0] prev_addr;
        logic [31:0] e;
        prev_hold = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst && prev_hold && !redirect_valid) begin
                chk("req_hold_valid", 32'(req_valid), 32'd1);
                chk("req_hold_addr", req_addr, prev_addr);
            end
            prev_hold = req_valid && !req_ready;
            prev_addr = req_addr;
            if (req_valid && req_ready) begin
                req_fires++;
                pend.push_back('{addr: req_addr, due: cyc + lat});
            end
            if (id_valid && id_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got pc %h expected none", id_pc);
                end else begin
                    e = sb.pop_front();
                    chk("id_pc", id_pc, e);
                    chk("id_instr", id_instr, instr_of(e));
                    chk("id_pc_plus_4", id_pc4, e + 32'd4);
                end
            end else if (!id_valid) begin
                chk("id_idle_zero", id_pc | id_instr | id_pc4, 32'd0);
            end
        end
    end

    initial begin
        int p0;
        int f0;
        rst            = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick(3);
        @(negedge clk);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_addr", req_addr, RESET_PC);
        chk("rst_id_pc", id_pc, 32'd0);

        // Streaming, 1-cycle memory, decode always ready
        tick();
        rst      = 1'b0;
        id_ready = 1'b1;
        sb_load(RESET_PC);
        @(negedge clk);
        chk("first_req_valid", 32'(req_valid), 32'd1);
        chk("first_req_addr", req_addr, RESET_PC);
        chk("first_id_valid", 32'(id_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("second_req_addr", req_addr, RESET_PC + 32'd4);
        chk("pre_fill_id_valid", 32'(id_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("fill_to_decode_valid", 32'(id_valid), 32'd1);
        tick(2);
        p0 = pops;
        tick(16);
        chk("throughput", 32'(pops - p0), 32'd16);

        // Redirect with decode stalled: exactly DEPTH requests, then full
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        sb_load(32'h200);
        @(negedge clk);
        chk("redir_req_valid", 32'(req_valid), 32'd0);
        chk("redir_id_valid", 32'(id_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        f0 = req_fires;
        tick(10);
        chk("stall_req_issued", 32'(req_fires - f0), 32'd4);
        @(negedge clk);
        chk("stall_count", 32'(count), 32'd4);
        chk("stall_req_valid", 32'(req_valid), 32'd0);
        chk("stall_id_valid", 32'(id_valid), 32'd1);
        chk("stall_head_pc", id_pc, 32'h200);
        tick();
        id_ready = 1'b1;
        p0 = pops;
        tick(20);
        chk("stall_drain", 32'(pops - p0 >= 15), 32'd1);

        // 3-cycle memory, then redirect with responses in flight
        lat = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        sb_load(32'h300);
        tick();
        redirect_valid = 1'b0;
        tick(20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        sb_load(32'h100);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_next_req_valid", 32'(req_valid), 32'd1);
        chk("redir_next_req_addr", req_addr, 32'h100);
        p0 = pops;
        tick(15);
        chk("redir_progress", 32'(pops - p0 >= 8), 32'd1);

        // Redirect coinciding with a response and a dequeue
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        sb_load(32'h400);
        @(negedge clk);
        chk("coinc_id_valid", 32'(id_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("coinc_count_after", 32'(count), 32'd0);
        chk("coinc_id_valid_after", 32'(id_valid), 32'd0);
        tick(15);

        // Back-to-back redirects; only the second target survives
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        sb_load(32'h500);
        tick();
        redirect_pc = 32'h600;
        sb_load(32'h600);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("b2b_req_valid", 32'(req_valid), 32'd1);
        chk("b2b_req_addr", req_addr, 32'h600);
        tick(15);

        // Random memory backpressure and decode stalls
        lat            = 2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h700;
        sb_load(32'h700);
        tick();
        redirect_valid = 1'b0;
        rand_mode      = 1'b1;
        repeat (60) begin
            id_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rand_mode = 1'b0;
        id_ready  = 1'b1;
        tick(20);

        // Reset while full
        id_ready = 1'b0;
        tick(12);
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        chk("full_req_valid", 32'(req_valid), 32'd0);
        tick();
        rst = 1'b1;
        sb_load(RESET_PC);
        @(negedge clk);
        chk("rst_full_count", 32'(count), 32'd0);
        chk("rst_full_id_valid", 32'(id_valid), 32'd0);
        chk("rst_full_req_valid", 32'(req_valid), 32'd0);
        chk("rst_full_addr", req_addr, RESET_PC);
        tick();
        rst      = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_id_valid", 32'(id_valid), 32'd0);
        chk("post_rst_req_valid", 32'(req_valid), 32'd1);
        chk("post_rst_req_addr", req_addr, RESET_PC);
        p0 = pops;
        tick(15);
        chk("post_rst_progress", 32'(pops - p0 >= 10), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
